sdram_port_arbiter: RTL and testbench

- Shares the single 8-bit SDRAM controller port between three requesters:
  - the ioctl download writer (tape/cartridge image loading);
  - the cassette player read channel (rd0);
  - a cartridge/ROM read channel (rd1).
- Sits between those requesters and the sdram controller in the core top level.
- Buffers download writes, applies fixed write priority with round-robin between the reads, and keeps one SDRAM transaction in flight, with timeout recovery.

---
 rtl/sdram_port_arbiter.sv | 241 ++++++++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares the single 8-bit SDRAM controller port between the ioctl download
//   writer and two read channels: rd0 is the cassette player and rd1 is the
//   cartridge/ROM fetch. Download writes are buffered in a small FIFO and
//   always win arbitration. The two reads alternate when both are waiting.
//   Only one SDRAM transaction is in flight at a time. A transaction that never
//   sees mem_ready is abandoned after TIMEOUT wait cycles.
//
// Ports
//   clk, reset           system clock and asynchronous active-low reset
//   wr_req/addr/data     one-cycle download write strobe with its address and byte
//   wr_full              write buffer holds WFIFO_DEPTH entries (registered)
//   wr_overflow          sticky flag: a write arrived while the buffer was full
//   rdN_req/addr         one-cycle read strobe; ignored while rdN_busy is high
//   rdN_busy             read pending or in flight
//   rdN_data/valid       read result (held) and its one-cycle update pulse
//   mem_addr/din         SDRAM address and write data, stable from ISSUE to IDLE
//   mem_rd/mem_we        one-cycle SDRAM command strobes
//   mem_dout/mem_ready   SDRAM read data and transaction-complete pulse
//   timeout_err          sticky flag: a transaction timed out
module sdram_port_arbiter #(
  parameter int AW          = 25,
  parameter int WFIFO_DEPTH = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          wr_full,
  output logic          wr_overflow,
  input  logic          rd0_req,
  input  logic [AW-1:0] rd0_addr,
  output logic          rd0_busy,
  output logic [7:0]    rd0_data,
  output logic          rd0_valid,
  input  logic          rd1_req,
  input  logic [AW-1:0] rd1_addr,
  output logic          rd1_busy,
  output logic [7:0]    rd1_data,
  output logic          rd1_valid,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  output logic          mem_rd,
  output logic          mem_we,
  input  logic [7:0]    mem_dout,
  input  logic          mem_ready,
  output logic          timeout_err
);

  localparam int PW = $clog2(WFIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic [1:0] {G_WR, G_RD0, G_RD1} gnt_t;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wentry_t;

  // ---------------- write buffer ----------------
  wentry_t       fifo_mem [WFIFO_DEPTH];
  logic [PW:0]   wptr_q, wptr_d, rptr_q, rptr_d, occ, occ_nx;
  logic          full_q, full_d, ovf_q, ovf_d;
  logic          fifo_empty, push, pop;
  wentry_t       head;

  assign fifo_empty = (wptr_q == rptr_q);
  assign occ        = wptr_q - rptr_q;
  assign head       = fifo_mem[rptr_q[PW-1:0]];
  // A pop in the same cycle frees a slot, so a push to a full buffer still lands.
  assign push       = wr_req && (!full_q || pop);
  assign occ_nx     = occ + (PW+1)'(push) - (PW+1)'(pop);
  assign full_d     = (occ_nx == (PW+1)'(WFIFO_DEPTH));
  assign wptr_d     = wptr_q + (PW+1)'(push);
  assign rptr_d     = rptr_q + (PW+1)'(pop);
  assign ovf_d      = ovf_q | (wr_req & ~push);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q[PW-1:0]] <= '{addr: wr_addr, data: wr_data};
  end

  // ---------------- read channels + FSM ----------------
  logic [1:0]          rd_req;
  logic [1:0][AW-1:0]  rd_addr_in;
  logic [1:0]          pend_q, pend_d;
  logic [1:0][AW-1:0]  raddr_q, raddr_d;
  logic [1:0][7:0]     rdata_q, rdata_d;
  logic [1:0]          valid_q, valid_d;

  state_t         state_q, state_d;
  gnt_t           gnt_q, gnt_d;
  logic           rr_q, rr_d;          // 0: rd0 wins the next contested grant
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  maddr_q, maddr_d;
  logic [7:0]     mdin_q, mdin_d;
  logic           mrd_q, mrd_d, mwe_q, mwe_d;
  logic           terr_q, terr_d;
  logic           sel, fin, gch;
  logic [7:0]     fin_val;

  assign rd_req     = {rd1_req, rd0_req};
  assign rd_addr_in = {rd1_addr, rd0_addr};
  assign gch        = (gnt_q == G_RD1);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    maddr_d = maddr_q;
    mdin_d  = mdin_q;
    mrd_d   = 1'b0;
    mwe_d   = 1'b0;
    pop     = 1'b0;
    pend_d  = pend_q;
    raddr_d = raddr_q;
    rdata_d = rdata_q;
    valid_d = '0;
    terr_d  = terr_q;
    sel     = 1'b0;
    fin     = 1'b0;
    fin_val = 8'h00;

    for (int i = 0; i < 2; i++) begin
      if (rd_req[i] && !pend_q[i]) begin
        pend_d[i]  = 1'b1;
        raddr_d[i] = rd_addr_in[i];
      end
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          gnt_d   = G_WR;
          maddr_d = head.addr;
          mdin_d  = head.data;
          mwe_d   = 1'b1;
          state_d = ISSUE;
        end else if (|pend_q) begin
          // Pointer only moves on a contested grant; a lone read goes straight through.
          if (&pend_q) begin
            sel  = rr_q;
            rr_d = ~rr_q;
          end else begin
            sel = pend_q[1];
          end
          gnt_d   = sel ? G_RD1 : G_RD0;
          maddr_d = raddr_q[sel];
          mdin_d  = 8'h00;
          mrd_d   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_ready) begin
          fin     = 1'b1;
          fin_val = mem_dout;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Last of TIMEOUT wait cycles: give up; reads report 0xFF.
          fin     = 1'b1;
          fin_val = 8'hFF;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (fin) begin
      state_d = IDLE;
      if (gnt_q != G_WR) begin
        rdata_d[gch] = fin_val;
        valid_d[gch] = 1'b1;
        pend_d[gch]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      state_q <= IDLE;
      gnt_q   <= G_WR;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      maddr_q <= '0;
      mdin_q  <= '0;
      mrd_q   <= 1'b0;
      mwe_q   <= 1'b0;
      pend_q  <= '0;
      raddr_q <= '0;
      rdata_q <= '0;
      valid_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      maddr_q <= maddr_d;
      mdin_q  <= mdin_d;
      mrd_q   <= mrd_d;
      mwe_q   <= mwe_d;
      pend_q  <= pend_d;
      raddr_q <= raddr_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      terr_q  <= terr_d;
    end
  end

  assign wr_full     = full_q;
  assign wr_overflow = ovf_q;
  assign rd0_busy    = pend_q[0];
  assign rd1_busy    = pend_q[1];
  assign rd0_data    = rdata_q[0];
  assign rd1_data    = rdata_q[1];
  assign rd0_valid   = valid_q[0];
  assign rd1_valid   = valid_q[1];
  assign mem_addr    = maddr_q;
  assign mem_din     = mdin_q;
  assign mem_rd      = mrd_q;
  assign mem_we      = mwe_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level reference model (write
// queue, pending-read flags, round-robin bit, in-flight transaction record).
module tb_sdram_port_arbiter;
  localparam int AW = 25, DEPTH = 4, TMO = 255;

  logic clk = 1'b0, reset = 1'b1;
  logic wr_req = 0, rd0_req = 0, rd1_req = 0, mem_ready = 0;
  logic [AW-1:0] wr_addr = '0, rd0_addr = '0, rd1_addr = '0;
  logic [7:0] wr_data = '0, mem_dout = '0;
  logic wr_full, wr_overflow, rd0_busy, rd1_busy, rd0_valid, rd1_valid;
  logic mem_rd, mem_we, timeout_err;
  logic [7:0] rd0_data, rd1_data, mem_din;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.AW(AW), .WFIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_full(wr_full), .wr_overflow(wr_overflow),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_busy(rd0_busy),
    .rd0_data(rd0_data), .rd0_valid(rd0_valid),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_busy(rd1_busy),
    .rd1_data(rd1_data), .rd1_valid(rd1_valid),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd), .mem_we(mem_we),
    .mem_dout(mem_dout), .mem_ready(mem_ready), .timeout_err(timeout_err)
  );

  int n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [AW-1:0] a; logic [7:0] d; } wr_t;
  typedef struct packed { logic w; logic [AW-1:0] a; } iss_t;
  wr_t  wq[$];
  iss_t log_q[$];
  bit m_pend[2];
  logic [AW-1:0] m_addr[2];
  logic [7:0] m_data[2];
  bit m_rr, m_idle, m_inflight, m_infl_wr, m_ovf, m_terr;
  bit m_ch;
  int m_k, m_delay;
  logic [7:0] m_rdata;
  int resp_mode = 0;   // >0 fixed mem_ready delay, 0 random 1..5, <0 never
  int force_dout = -1;
  int vcnt[2];

  task automatic model_reset();
    wq.delete();
    m_pend = '{0, 0}; m_addr = '{'0, '0}; m_data = '{8'h00, 8'h00};
    m_rr = 0; m_idle = 1; m_inflight = 0; m_infl_wr = 0; m_ovf = 0; m_terr = 0;
    m_ch = 0; m_k = 0; m_delay = -1; m_rdata = 8'h00;
  endtask

  task automatic observe();
    bit exp_issue, pp0, pp1, ev0, ev1, fin, ch;
    logic [7:0] fv;
    int code;
    wr_t w;
    pp0 = m_pend[0]; pp1 = m_pend[1];
    ev0 = 0; ev1 = 0; fin = 0; fv = 8'h00;
    exp_issue = m_idle && (wq.size() != 0 || m_pend[0] || m_pend[1]);
    code = !exp_issue ? 0 : (wq.size() != 0 ? 2 : 1);
    chk("issue_strobe", {30'b0, mem_we, mem_rd}, code);
    if (exp_issue) begin
      if (wq.size() != 0) begin
        w = wq.pop_front();
        chk("wr_mem_addr", mem_addr, w.a);
        chk("wr_mem_din", mem_din, w.d);
        m_infl_wr = 1;
        log_q.push_back('{w: 1'b1, a: mem_addr});
      end else begin
        if (m_pend[0] && m_pend[1]) begin ch = m_rr; m_rr = !m_rr; end
        else ch = m_pend[1];
        chk("rd_mem_addr", mem_addr, m_addr[ch]);
        m_infl_wr = 0; m_ch = ch;
        log_q.push_back('{w: 1'b0, a: mem_addr});
      end
      m_inflight = 1; m_idle = 0; m_k = 0;
      m_delay = resp_mode > 0 ? resp_mode : (resp_mode == 0 ? int'($urandom_range(5, 1)) : -1);
      m_rdata = force_dout >= 0 ? 8'(force_dout) : 8'($urandom);
    end else if (m_inflight) begin
      m_k++;
      if (mem_ready && m_k >= 2) begin fin = 1; fv = m_rdata; end
      else if (m_k == TMO + 1) begin fin = 1; fv = 8'hFF; m_terr = 1; end
      if (fin) begin
        if (!m_infl_wr) begin
          m_data[m_ch] = fv; m_pend[m_ch] = 0;
          if (m_ch) ev1 = 1; else ev0 = 1;
        end
        m_inflight = 0; m_idle = 1;
      end
    end
    chk("rd0_valid", rd0_valid, ev0);
    chk("rd1_valid", rd1_valid, ev1);
    chk("rd0_data", rd0_data, m_data[0]);
    chk("rd1_data", rd1_data, m_data[1]);
    if (rd0_valid) vcnt[0]++;
    if (rd1_valid) vcnt[1]++;
    if (wr_req) begin
      if (wq.size() < DEPTH) wq.push_back('{a: wr_addr, d: wr_data});
      else m_ovf = 1;
    end
    if (rd0_req && !pp0) begin m_pend[0] = 1; m_addr[0] = rd0_addr; end
    if (rd1_req && !pp1) begin m_pend[1] = 1; m_addr[1] = rd1_addr; end
    chk("rd0_busy", rd0_busy, m_pend[0]);
    chk("rd1_busy", rd1_busy, m_pend[1]);
    chk("wr_full", wr_full, wq.size() == DEPTH);
    chk("wr_overflow", wr_overflow, m_ovf);
    chk("timeout_err", timeout_err, m_terr);
  endtask

  // One clock: observe 1ns after the edge, clear strobes, then play SDRAM responder.
  task automatic step();
    @(posedge clk); #1;
    observe();
    wr_req = 0; rd0_req = 0; rd1_req = 0; mem_ready = 0;
    if (m_inflight && m_delay > 0 && m_k == m_delay) begin
      mem_ready = 1; mem_dout = m_rdata;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((!m_idle || wq.size() != 0 || m_pend[0] || m_pend[1]) && n < 3000) begin
      step(); n++;
    end
    chk("drain_bound", n < 3000, 1);
  endtask

  // Reset with a stray mem_ready held across release.
  task automatic do_reset();
    wr_req = 0; rd0_req = 0; rd1_req = 0;
    reset = 0; mem_ready = 1; #2;
    chk("rst_flags", {mem_rd, mem_we, rd0_valid, rd1_valid, rd0_busy, rd1_busy,
                      wr_full, wr_overflow, timeout_err}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_rd0_data", rd0_data, 0);
    chk("rst_rd1_data", rd1_data, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1;
  endtask

  initial begin
    int n;
    model_reset();
    #1 do_reset();
    step();

    // Single read, fixed 3-cycle memory latency
    resp_mode = 3; force_dout = 8'h5A;
    rd0_addr = 25'h000123; rd0_req = 1; step();
    chk("t1_busy_rise", rd0_busy, 1);
    step();
    chk("t1_mem_rd", mem_rd, 1);
    chk("t1_mem_addr", mem_addr, 25'h000123);
    repeat (3) step();
    chk("t1_no_early_valid", rd0_valid, 0);
    step();
    chk("t1_valid", rd0_valid, 1);
    chk("t1_data", rd0_data, 8'h5A);
    chk("t1_busy_fall", rd0_busy, 0);
    force_dout = -1;

    // Priority then round-robin
    resp_mode = 0; log_q.delete();
    wr_addr = 25'h10; wr_data = 8'hAA; wr_req = 1;
    rd0_addr = 25'h0A0; rd0_req = 1; rd1_addr = 25'h0B1; rd1_req = 1;
    step(); drain();
    chk("t2_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("t2_first_wr", log_q[0], {1'b1, 25'h10});
      chk("t2_second_rd0", log_q[1], {1'b0, 25'h0A0});
      chk("t2_third_rd1", log_q[2], {1'b0, 25'h0B1});
    end
    log_q.delete();
    rd0_addr = 25'h0C0; rd0_req = 1; rd1_addr = 25'h0D1; rd1_req = 1;
    step(); drain();
    chk("t2b_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t2b_first_rd1", log_q[0], {1'b0, 25'h0D1});
      chk("t2b_second_rd0", log_q[1], {1'b0, 25'h0C0});
    end

    // Overflow: five writes while a slow read holds the port
    resp_mode = 20;
    rd0_addr = 25'h300; rd0_req = 1; step(); step();
    resp_mode = 0; log_q.delete();
    for (int i = 0; i < 5; i++) begin
      wr_addr = 25'h400 + AW'(i); wr_data = 8'(i * 17 + 1); wr_req = 1; step();
      if (i == 3) chk("t3_full", wr_full, 1);
    end
    chk("t3_overflow", wr_overflow, 1);
    drain();
    chk("t3_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < log_q.size()) chk("t3_order", log_q[i], {1'b1, 25'h400 + AW'(i)});
    chk("t3_overflow_sticky", wr_overflow, 1);

    // Timeout on rd1 with rd0 queued behind it
    resp_mode = -1;
    rd1_addr = 25'h555; rd1_req = 1; step(); step();
    rd0_addr = 25'h666; rd0_req = 1; step();
    n = 0;
    while (!rd1_valid && n < 400) begin step(); n++; end
    chk("t4_valid_seen", rd1_valid, 1);
    chk("t4_wait_len", n, 255);
    chk("t4_timeout_err", timeout_err, 1);
    chk("t4_data_ff", rd1_data, 8'hFF);
    resp_mode = 2; log_q.delete();
    drain();
    chk("t4_rd0_served", log_q.size(), 1);
    if (log_q.size() == 1) chk("t4_rd0_addr", log_q[0], {1'b0, 25'h666});

    // Busy ignore
    resp_mode = 4; vcnt = '{0, 0}; log_q.delete();
    rd0_addr = 25'h100; rd0_req = 1; step(); step();
    rd0_addr = 25'h200; rd0_req = 1; step();
    rd0_req = 1; step();
    drain();
    chk("t5_one_issue", log_q.size(), 1);
    if (log_q.size() == 1) chk("t5_addr", log_q[0], {1'b0, 25'h100});
    chk("t5_one_valid", vcnt[0], 1);

    // Reset mid-WAIT, stray mem_ready, then a normal read
    resp_mode = -1;
    rd0_addr = 25'h777; rd0_req = 1; step(); step();
    repeat (5) step();
    do_reset();
    vcnt = '{0, 0};
    repeat (4) step();
    chk("t6_no_valid", vcnt[0] + vcnt[1], 0);
    resp_mode = 2; force_dout = 8'h3C;
    rd1_addr = 25'h888; rd1_req = 1; step();
    drain();
    chk("t6_rd1_data", rd1_data, 8'h3C);
    chk("t6_rd1_one_valid", vcnt[1], 1);
    force_dout = -1;

    // Random traffic
    resp_mode = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 20) begin
        wr_req = 1; wr_addr = AW'($urandom); wr_data = 8'($urandom);
      end
      if ($urandom_range(99) < 15) begin rd0_req = 1; rd0_addr = AW'($urandom); end
      if ($urandom_range(99) < 15) begin rd1_req = 1; rd1_addr = AW'($urandom); end
      step();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
